step_clk_ctrl: RTL and testbench
================================

Name: step_clk_ctrl

Overview:
- Consumer end of the board clocking path. Replaces the free-running slow divided clock with a single-cycle clock enable `cpu_en`, generated in the fast `clk` domain.
- Accepts two raw, bouncy push-buttons:
  - `btn_step`: advances the CPU one cycle.
  - `btn_run`: toggles between auto-run and single-step.
- Synchronises and debounces both buttons, and issues exactly one `cpu_en` pulse per accepted step press, or one pulse per auto-run tick.
- Sits between the board I/O pins and the CPU datapath enable.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz). Must be ≥2.
- CNT_W, 20: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- AUTO_DIV, 24: auto-run period is 2^AUTO_DIV clk cycles (about 3 Hz at 50 MHz).

Ports:
- clk, in, 1: system clock.
- clr, in, 1: reset, asynchronous, active-low.
- btn_step, in, 1: raw step button, asynchronous to clk, active-high.
- btn_run, in, 1: raw run/step toggle button, asynchronous, active-high.
- halt, in, 1: synchronous CPU halt request, active-high.
- cpu_en, out, 1: one-cycle clock-enable pulse to the CPU.
- run_mode, out, 1: 1 = RUN, 0 = STEP.
- en_count, out, 16: number of cpu_en pulses issued since reset.

Behaviour:
- Reset (clr=0, asynchronous):
  - cpu_en=0, run_mode=0 (STEP), en_count=0.
  - Synchronisers, debounced levels, debounce counters and auto-run divider all 0.
  - Reset asserted mid-debounce or mid-period discards all progress.
- Synchroniser: each button passes through 2 flops; s2 is the synchronised level.
- Debouncer (one per button):
  - Holds a debounced level `db`, initially 0.
  - Each cycle s2==db: counter <= 0.
  - Each cycle s2!=db: counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and s2!=db: db <= s2, counter <= 0.
  - Therefore db changes on the DEBOUNCE_CYCLES-th consecutive mismatch cycle. Any glitch shorter than that restarts the count.
- Edge detect: press = db rising (db=1, previous db=0), one cycle wide. Releases are debounced identically but produce no event.
- Mode FSM (states STEP, RUN):
  - STEP: run_press -> RUN; otherwise stay.
  - RUN: run_press or halt -> STEP.
  - STEP with halt: stay STEP.
  - halt takes priority over run_press in the same cycle (result STEP).
  - run_mode is the registered state.
- Auto-run divider (AUTO_DIV bits):
  - Counts only in RUN.
  - Cleared on any transition into or out of RUN, and held at 0 in STEP.
  - tick when divider == all-ones; the divider then wraps to 0.
  - First tick occurs 2^AUTO_DIV cycles after run_mode rises.
- cpu_en (registered):
  - In STEP: cpu_en <= step_press & ~halt.
  - In RUN: cpu_en <= tick & ~halt.
  - step_press in RUN is ignored (not queued).
  - A step_press in the same cycle as the STEP->RUN transition is evaluated against the current state (STEP) and is honoured.
- Latency: step_press cycle N -> cpu_en high in cycle N+1, for exactly 1 cycle. Never 2 consecutive cycles high.
- Press-to-pulse: button level stable at pin -> cpu_en after 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- en_count: increments in the cycle after cpu_en=1 (same edge cpu_en is seen registered). 16-bit, wraps 0xFFFF -> 0x0000 silently.
- Holding btn_step produces exactly one pulse; a second pulse requires release (debounced) then a new press.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, AUTO_DIV=3):
1. Reset, then btn_step held high 20 cycles -> exactly one cpu_en pulse, 7 cycles after the first sampled high; en_count=1; run_mode=0.
2. btn_step toggled high/low every 2 cycles for 30 cycles, then held low -> no cpu_en; en_count unchanged.
3. btn_run pressed 10 cycles -> run_mode=1; cpu_en pulses every 8 cycles, first 8 cycles after run_mode rise. After 5 pulses en_count=6. btn_step pressed during RUN -> no extra pulse.
4. In RUN, halt=1 for one cycle coinciding with a tick -> no cpu_en that cycle; run_mode=0 next cycle; no further auto pulses.
5. halt and run_press in the same cycle from RUN -> run_mode=0. From STEP -> run_mode stays 0.
6. Force en_count to 0xFFFF by 65535 pulses (or via RUN), then one more pulse -> en_count=0x0000. Assert clr=0 mid-debounce -> all outputs 0 immediately, and no pulse after release.

Source files
------------

// File: rtl/step_clk_ctrl.sv
// Button-driven CPU clock-enable generator: synchronises and debounces a step
// and a run/step toggle button, then issues single-cycle cpu_en pulses.
module step_clk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int AUTO_DIV        = 24
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic        halt,
    output logic        cpu_en,
    output logic        run_mode,
    output logic [15:0] en_count
);

    typedef enum logic {
        ST_STEP = 1'b0,
        ST_RUN  = 1'b1
    } mode_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the step button, bit 1 the run/step toggle button.
    logic [1:0]          w_btn;
    logic [1:0]          r_s1;
    logic [1:0]          r_s2;
    logic [1:0]          r_db;
    logic [1:0]          r_db_q;
    logic [CNT_W-1:0]    r_cnt [2];
    logic [1:0]          w_press;
    logic                w_step_press;
    logic                w_run_press;

    mode_t               r_state;
    logic [AUTO_DIV-1:0] r_div;
    logic                w_tick;
    logic                r_cpu_en;
    logic [15:0]         r_en_count;

    assign w_btn        = {btn_run, btn_step};
    assign w_press      = r_db & ~r_db_q;
    assign w_step_press = w_press[0];
    assign w_run_press  = w_press[1];
    assign w_tick       = (r_state == ST_RUN) && (&r_div);

    // Debounced level moves only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_db     <= '0;
            r_db_q   <= '0;
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            r_s1   <= w_btn;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // cpu_en is decided from the current mode, so a step press landing on the
    // STEP->RUN edge is still honoured; halt wins over a run press.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= ST_STEP;
            r_div      <= '0;
            r_cpu_en   <= 1'b0;
            r_en_count <= '0;
        end else begin
            case (r_state)
                ST_STEP: begin
                    r_cpu_en <= w_step_press & ~halt;
                    if (w_run_press && !halt) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_cpu_en <= w_tick & ~halt;
                    if (w_run_press || halt) begin
                        r_state <= ST_STEP;
                    end
                end
                default: begin
                    r_cpu_en <= 1'b0;
                    r_state  <= ST_STEP;
                end
            endcase

            // The divider restarts on every mode change so the first tick is a full period away.
            if (r_state == ST_RUN && !(w_run_press || halt)) begin
                r_div <= r_div + AUTO_DIV'(1);
            end else begin
                r_div <= '0;
            end

            if (r_cpu_en) begin
                r_en_count <= r_en_count + 16'd1;
            end
        end
    end

    assign cpu_en   = r_cpu_en;
    assign run_mode = (r_state == ST_RUN);
    assign en_count = r_en_count;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Bench for step_clk_ctrl: vector table of step presses plus hand-timed
// sequences for run mode, halt, counter wrap and asynchronous reset.
module tb_step_clk_ctrl;

    localparam int DB  = 4;
    localparam int PTP = DB + 3;  // pin level to cpu_en pulse, in cycles

    logic        clk;
    logic        clr;
    logic        btn_step;
    logic        btn_run;
    logic        halt;
    logic        cpu_en;
    logic        run_mode;
    logic [15:0] en_count;

    logic [31:0] cyc;
    logic [31:0] exp_q [$];
    logic [15:0] exp_cnt;
    int          checks;
    int          errors;

    typedef struct {
        int unsigned h;
        int unsigned l;
        bit          hlt;
        bit          exp_pulse;
    } vec_t;

    vec_t vecs [10];

    step_clk_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(3),
        .AUTO_DIV(3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .btn_step(btn_step),
        .btn_run(btn_run),
        .halt(halt),
        .cpu_en(cpu_en),
        .run_mode(run_mode),
        .en_count(en_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (clr === 1'b1 && cpu_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got cpu_en=1 want 0 cyc=%0d", cyc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL pulse_time got cyc=%0d want cyc=%0d", cyc, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_until(input logic [31:0] t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic step_vec(input vec_t v);
        logic [31:0] c;
        c = cyc;
        btn_step = 1'b1;
        halt     = v.hlt;
        if (v.exp_pulse) begin
            exp_q.push_back(c + PTP);
            exp_cnt = exp_cnt + 16'd1;
        end
        wait_until(c + v.h);
        btn_step = 1'b0;
        wait_until(c + v.h + v.l);
        halt = 1'b0;
        chk("vec_count", {16'd0, en_count}, {16'd0, exp_cnt});
        chk("vec_pending", exp_q.size(), 0);
        chk("vec_mode", {31'd0, run_mode}, 0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [31:0] c;
        checks   = 0;
        errors   = 0;
        exp_cnt  = '0;
        clr      = 1'b0;
        btn_step = 1'b0;
        btn_run  = 1'b0;
        halt     = 1'b0;

        vecs[0] = '{h: 20, l: 8,  hlt: 1'b0, exp_pulse: 1'b1};
        vecs[1] = '{h: 1,  l: 8,  hlt: 1'b0, exp_pulse: 1'b0};
        vecs[2] = '{h: 3,  l: 8,  hlt: 1'b0, exp_pulse: 1'b0};
        vecs[3] = '{h: 4,  l: 8,  hlt: 1'b0, exp_pulse: 1'b1};
        vecs[4] = '{h: 6,  l: 8,  hlt: 1'b1, exp_pulse: 1'b0};
        vecs[5] = '{h: 5,  l: 10, hlt: 1'b0, exp_pulse: 1'b1};
        for (int i = 6; i < 10; i++) begin
            vecs[i].h         = $urandom_range(1, 8);
            vecs[i].l         = 8;
            vecs[i].hlt       = 1'($urandom_range(0, 1));
            vecs[i].exp_pulse = (vecs[i].h >= DB) && !vecs[i].hlt;
        end

        repeat (3) @(negedge clk);
        chk("rst_cpu_en", {31'd0, cpu_en}, 0);
        chk("rst_run_mode", {31'd0, run_mode}, 0);
        chk("rst_en_count", {16'd0, en_count}, 0);
        clr = 1'b1;
        repeat (2) @(negedge clk);

        // Step presses of varying width, with and without halt
        for (int i = 0; i < 10; i++) step_vec(vecs[i]);

        // Bounce faster than the debounce window: no pulse
        for (int i = 0; i < 15; i++) begin
            btn_step = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn_step = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_count", {16'd0, en_count}, {16'd0, exp_cnt});
        chk("bounce_pending", exp_q.size(), 0);

        // Run mode: ticks every 8 cycles, step ignored, halt on a tick exits
        c = cyc;
        btn_run = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(c + 15 + 8 * k);
        exp_cnt = exp_cnt + 16'd5;
        wait_until(c + 6);
        chk("run_mode_before_rise", {31'd0, run_mode}, 0);
        wait_until(c + 7);
        chk("run_mode_rise", {31'd0, run_mode}, 1);
        wait_until(c + 10);
        btn_run = 1'b0;
        wait_until(c + 20);
        btn_step = 1'b1;
        wait_until(c + 26);
        btn_step = 1'b0;
        wait_until(c + 54);
        chk("run_count5", {16'd0, en_count}, {16'd0, exp_cnt});
        chk("run_mode_held", {31'd0, run_mode}, 1);
        halt = 1'b1;
        wait_until(c + 55);
        halt = 1'b0;
        chk("halt_tick_cpu_en", {31'd0, cpu_en}, 0);
        chk("halt_exit_mode", {31'd0, run_mode}, 0);
        wait_until(c + 85);
        chk("halt_after_count", {16'd0, en_count}, {16'd0, exp_cnt});
        chk("halt_after_pending", exp_q.size(), 0);

        // From RUN: halt and run press together, also on a tick
        c = cyc;
        btn_run = 1'b1;
        exp_q.push_back(c + 15);
        exp_cnt = exp_cnt + 16'd1;
        wait_until(c + 5);
        btn_run = 1'b0;
        wait_until(c + 7);
        chk("run2_rise", {31'd0, run_mode}, 1);
        wait_until(c + 16);
        btn_run = 1'b1;
        wait_until(c + 21);
        btn_run = 1'b0;
        wait_until(c + 22);
        chk("run2_before_exit", {31'd0, run_mode}, 1);
        halt = 1'b1;
        wait_until(c + 23);
        halt = 1'b0;
        chk("halt_runpress_run", {31'd0, run_mode}, 0);
        wait_until(c + 45);
        chk("run2_count", {16'd0, en_count}, {16'd0, exp_cnt});
        chk("run2_pending", exp_q.size(), 0);

        // From STEP: halt and run press together keeps STEP
        c = cyc;
        btn_run = 1'b1;
        wait_until(c + 5);
        btn_run = 1'b0;
        wait_until(c + 6);
        halt = 1'b1;
        wait_until(c + 7);
        halt = 1'b0;
        chk("halt_runpress_step", {31'd0, run_mode}, 0);
        wait_until(c + 25);
        chk("step_stays", {31'd0, run_mode}, 0);
        chk("step_stays_pending", exp_q.size(), 0);

        // Counter wrap from a preloaded value
        force dut.r_en_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_en_count;
        exp_cnt = 16'hFFFE;
        @(negedge clk);
        chk("preload", {16'd0, en_count}, 32'h0000_FFFE);
        step_vec('{h: 5, l: 8, hlt: 1'b0, exp_pulse: 1'b1});
        chk("cnt_ffff", {16'd0, en_count}, 32'h0000_FFFF);
        step_vec('{h: 5, l: 8, hlt: 1'b0, exp_pulse: 1'b1});
        chk("cnt_wrap", {16'd0, en_count}, 32'h0000_0000);
        step_vec('{h: 5, l: 8, hlt: 1'b0, exp_pulse: 1'b1});

        // Asynchronous reset in RUN, mid-debounce and mid-period
        c = cyc;
        btn_run = 1'b1;
        wait_until(c + 5);
        btn_run = 1'b0;
        wait_until(c + 8);
        chk("pre_clr_mode", {31'd0, run_mode}, 1);
        wait_until(c + 10);
        btn_step = 1'b1;
        wait_until(c + 12);
        #2;
        clr = 1'b0;
        #1;
        exp_cnt = '0;
        chk("clr_cpu_en", {31'd0, cpu_en}, 0);
        chk("clr_run_mode", {31'd0, run_mode}, 0);
        chk("clr_en_count", {16'd0, en_count}, 0);
        btn_step = 1'b0;
        wait_until(c + 14);
        clr = 1'b1;
        btn_step = 1'b1;
        wait_until(c + 16);
        btn_step = 1'b0;
        wait_until(c + 45);
        chk("post_clr_mode", {31'd0, run_mode}, 0);
        chk("post_clr_count", {16'd0, en_count}, 0);
        chk("post_clr_pending", exp_q.size(), 0);

        // Normal operation resumes after reset
        step_vec('{h: 6, l: 8, hlt: 1'b0, exp_pulse: 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
